// File: rtl/life_grid.sv
// life_grid: ROWS x COLS Life-like cellular automaton.
// Programmable birth/survive rule, toroidal or dead-edge boundary, and a
// row-serial engine: one row of the next grid is computed per CALC cycle
// into a shadow buffer, then the whole buffer is committed in one edge.
module life_grid #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int WRAP  = 1,
   parameter int GEN_W = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [8:0]                         birth_mask,
   input  logic [8:0]                         survive_mask,
   input  logic                               load,
   input  logic [ROWS*COLS-1:0]               load_data,
   input  logic                               step,
   input  logic                               run,
   output logic [ROWS*COLS-1:0]               cells,
   output logic                               busy,
   output logic                               done,
   output logic [GEN_W-1:0]                   generation,
   output logic [$clog2(ROWS*COLS+1)-1:0]     population,
   output logic                               stable,
   output logic                               extinct
);

   localparam int N  = ROWS * COLS;
   localparam int PW = $clog2(N + 1);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     row_q, row_d;
   logic [N-1:0]      cells_q, cells_d;
   logic [N-1:0]      buf_q, buf_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic [PW-1:0]     pop_q, pop_d;
   logic              stable_q, stable_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [COLS-1:0]   row_next;

   // Number of live cells in a grid image.
   function automatic logic [PW-1:0] popcount(input logic [N-1:0] g);
      logic [PW-1:0] s;
      logic [N-1:0]  t;
      s = '0;
      t = g;
      for (int i = 0; i < N; i++) begin
         s = s + PW'(t[0]);
         t = t >> 1;
      end
      return s;
   endfunction

   // Cell state at (r, c); coordinates may lie one step outside the grid.
   // Out-of-grid coordinates wrap when WRAP is set, otherwise read as dead.
   function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
      int           rr;
      int           cc;
      logic [N-1:0] t;
      rr = r;
      cc = c;
      if (WRAP != 0) begin
         rr = (r + ROWS) % ROWS;
         cc = (c + COLS) % COLS;
      end else if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
         return 1'b0;
      end
      t = g >> (rr * COLS + cc);
      return t[0];
   endfunction

   // Next-generation values of the row currently addressed by row_q.
   always_comb begin : calc_row
      int         r;
      logic [3:0] n;
      logic       self;
      r        = int'(row_q);
      n        = '0;
      self     = 1'b0;
      row_next = '0;
      for (int c = 0; c < COLS; c++) begin
         n = '0;
         for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
               if (dr != 0 || dc != 0) begin
                  n = n + {3'b000, cell_at(cells_q, r + dr, c + dc)};
               end
            end
         end
         self     = cell_at(cells_q, r, c);
         // Shift in from the top so that column 0 ends up in bit 0.
         row_next = {(self ? survive_mask[n] : birth_mask[n]), row_next[COLS-1:1]};
      end
   end

   // Control FSM and next-state of all registered outputs; load wins in any state.
   always_comb begin : fsm_next
      logic [N-1:0] row_mask;
      int           sh;
      state_d  = state_q;
      row_d    = row_q;
      cells_d  = cells_q;
      buf_d    = buf_q;
      gen_d    = gen_q;
      pop_d    = pop_q;
      stable_d = stable_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sh       = int'(row_q) * COLS;
      row_mask = {{(N-COLS){1'b0}}, {COLS{1'b1}}} << sh;
      case (state_q)
         IDLE: begin
            if (step || run) begin
               state_d = CALC;
               row_d   = '0;
               busy_d  = 1'b1;
            end
         end
         CALC: begin
            buf_d = (buf_q & ~row_mask) | ({{(N-COLS){1'b0}}, row_next} << sh);
            if (row_q == RW'(ROWS - 1)) begin
               state_d = COMMIT;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         COMMIT: begin
            cells_d  = buf_q;
            stable_d = (buf_q == cells_q);
            pop_d    = popcount(buf_q);
            gen_d    = (gen_q == '1) ? gen_q : gen_q + 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
      if (load) begin
         cells_d  = load_data;
         gen_d    = '0;
         pop_d    = popcount(load_data);
         stable_d = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         state_d  = IDLE;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         row_q    <= '0;
         cells_q  <= '0;
         buf_q    <= '0;
         gen_q    <= '0;
         pop_q    <= '0;
         stable_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         cells_q  <= cells_d;
         buf_q    <= buf_d;
         gen_q    <= gen_d;
         pop_q    <= pop_d;
         stable_q <= stable_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign cells      = cells_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign generation = gen_q;
   assign population = pop_q;
   assign stable     = stable_q;
   assign extinct    = (pop_q == '0);

endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: an 8x8 toroidal instance (GEN_W=16) and an
// 8x8 dead-edge instance (GEN_W=2) driven by the same inputs.
module tb_life_grid;

   localparam int R  = 8;
   localparam int C  = 8;
   localparam int N  = R * C;
   localparam int PW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic [8:0]    birth_mask;
   logic [8:0]    survive_mask;
   logic          load;
   logic [N-1:0]  load_data;
   logic          step;
   logic          run;

   logic [N-1:0]  w_cells, d_cells;
   logic          w_busy, d_busy, w_done, d_done;
   logic [15:0]   w_gen;
   logic [1:0]    d_gen;
   logic [PW-1:0] w_pop, d_pop;
   logic          w_stable, d_stable, w_extinct, d_extinct;

   int checks = 0;
   int errors = 0;

   life_grid #(.ROWS(R), .COLS(C), .WRAP(1), .GEN_W(16)) dut_w (
      .clk(clk), .rst(rst), .birth_mask(birth_mask), .survive_mask(survive_mask),
      .load(load), .load_data(load_data), .step(step), .run(run),
      .cells(w_cells), .busy(w_busy), .done(w_done), .generation(w_gen),
      .population(w_pop), .stable(w_stable), .extinct(w_extinct)
   );

   life_grid #(.ROWS(R), .COLS(C), .WRAP(0), .GEN_W(2)) dut_d (
      .clk(clk), .rst(rst), .birth_mask(birth_mask), .survive_mask(survive_mask),
      .load(load), .load_data(load_data), .step(step), .run(run),
      .cells(d_cells), .busy(d_busy), .done(d_done), .generation(d_gen),
      .population(d_pop), .stable(d_stable), .extinct(d_extinct)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] cb(input int r, input int c);
      return 64'(1) << (r * C + c);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [N-1:0] p);
      load_data = p;
      load      = 1'b1;
      tick();
      load      = 1'b0;
   endtask

   // One step pulse; done must appear exactly ROWS+1 edges after acceptance.
   task automatic do_step(input string tag);
      int early;
      early = 0;
      step  = 1'b1;
      tick();
      step  = 1'b0;
      for (int i = 0; i < R; i++) begin
         tick();
         if (w_done || d_done) early++;
      end
      tick();
      check({tag, "_no_early_done"}, 64'(early), 64'd0);
      check({tag, "_done"}, 64'(w_done), 64'd1);
      check({tag, "_busy_clear"}, 64'(w_busy), 64'd0);
   endtask

   logic [N-1:0] vbar, hbar, blk, edge_h, seeds, lone, newp;
   int           gens, lastk, busy_cnt, done_cnt;
   logic         stop;

   initial begin
      rst = 1'b0; birth_mask = 9'h008; survive_mask = 9'h00C;
      load = 1'b0; load_data = '0; step = 1'b0; run = 1'b0;
      vbar   = cb(2,3) | cb(3,3) | cb(4,3);
      hbar   = cb(3,2) | cb(3,3) | cb(3,4);
      blk    = cb(3,3) | cb(3,4) | cb(4,3) | cb(4,4);
      edge_h = cb(0,0) | cb(0,1) | cb(0,2);
      seeds  = cb(3,3) | cb(3,4);
      lone   = cb(5,5);
      newp   = cb(1,1) | cb(6,6);

      // Reset state
      tick(); tick();
      check("rst_cells", 64'(w_cells), 64'd0);
      check("rst_busy", 64'(w_busy), 64'd0);
      check("rst_done", 64'(w_done), 64'd0);
      check("rst_gen", 64'(w_gen), 64'd0);
      check("rst_pop", 64'(w_pop), 64'd0);
      check("rst_stable", 64'(w_stable), 64'd0);
      check("rst_extinct", 64'(w_extinct), 64'd1);
      rst = 1'b1;
      tick();

      // Blinker, B3/S23
      do_load(vbar);
      check("load_cells", 64'(w_cells), 64'(vbar));
      check("load_pop", 64'(w_pop), 64'd3);
      check("load_gen", 64'(w_gen), 64'd0);
      do_step("blink1");
      check("blink1_cells", 64'(w_cells), 64'(hbar));
      check("blink1_gen", 64'(w_gen), 64'd1);
      check("blink1_pop", 64'(w_pop), 64'd3);
      check("blink1_stable", 64'(w_stable), 64'd0);
      tick();
      check("blink1_done_drop", 64'(w_done), 64'd0);
      do_step("blink2");
      check("blink2_cells", 64'(w_cells), 64'(vbar));
      check("blink2_gen", 64'(w_gen), 64'd2);

      // Block still life
      do_load(blk);
      do_step("block");
      check("block_cells", 64'(w_cells), 64'(blk));
      check("block_stable", 64'(w_stable), 64'd1);
      check("block_pop", 64'(w_pop), 64'd4);
      check("block_extinct", 64'(w_extinct), 64'd0);
      check("block_gen", 64'(w_gen), 64'd1);

      // Edge behaviour: toroidal vs dead edges
      do_load(edge_h);
      do_step("edge");
      check("edge_wrap_cells", 64'(w_cells), cb(7,1) | cb(0,1) | cb(1,1));
      check("edge_dead_cells", 64'(d_cells), cb(0,1) | cb(1,1));
      check("edge_dead_pop", 64'(d_pop), 64'd2);

      // Seeds B2/S-
      birth_mask = 9'h004; survive_mask = 9'h000;
      do_load(seeds);
      do_step("seeds");
      check("seeds_cells", 64'(w_cells), cb(2,3) | cb(2,4) | cb(4,3) | cb(4,4));
      check("seeds_pop", 64'(w_pop), 64'd4);
      do_load(lone);
      do_step("lone");
      check("lone_pop", 64'(w_pop), 64'd0);
      check("lone_extinct", 64'(w_extinct), 64'd1);
      check("lone_cells", 64'(w_cells), 64'd0);

      // Step pulsed while busy is dropped
      birth_mask = 9'h008; survive_mask = 9'h00C;
      do_load(vbar);
      step = 1'b1; tick(); step = 1'b0;
      tick();
      step = 1'b1; tick(); step = 1'b0;
      repeat (R - 1) tick();
      check("ign_done", 64'(w_done), 64'd1);
      check("ign_cells", 64'(w_cells), 64'(hbar));
      busy_cnt = 0;
      for (int i = 0; i < R + 3; i++) begin
         tick();
         if (w_busy) busy_cnt++;
      end
      check("ign_no_second_gen", 64'(busy_cnt), 64'd0);
      check("ign_gen", 64'(w_gen), 64'd1);

      // Abort by load on the third CALC cycle
      do_load(vbar);
      step = 1'b1; tick(); step = 1'b0;
      check("abort_busy_set", 64'(w_busy), 64'd1);
      tick(); tick();
      do_load(newp);
      check("abort_busy", 64'(w_busy), 64'd0);
      check("abort_done", 64'(w_done), 64'd0);
      check("abort_cells", 64'(w_cells), 64'(newp));
      check("abort_gen", 64'(w_gen), 64'd0);
      done_cnt = 0;
      for (int i = 0; i < R + 4; i++) begin
         tick();
         if (w_done || w_busy) done_cnt++;
      end
      check("abort_quiet", 64'(done_cnt), 64'd0);
      check("abort_cells_hold", 64'(w_cells), 64'(newp));

      // Free run: period ROWS+2, 2-bit generation saturates at 3
      do_load(vbar);
      run   = 1'b1;
      gens  = 0;
      lastk = 0;
      stop  = 1'b0;
      for (int k = 1; k <= 80 && !stop; k++) begin
         tick();
         if (d_done) begin
            gens++;
            check($sformatf("run_period%0d", gens), 64'(k - lastk), 64'd10);
            check($sformatf("run_dgen%0d", gens), 64'(d_gen), 64'((gens > 3) ? 3 : gens));
            lastk = k;
            if (gens == 5) stop = 1'b1;
         end
      end
      check("run_gens_seen", 64'(gens), 64'd5);
      check("run_wgen", 64'(w_gen), 64'd5);
      check("run_cells", 64'(w_cells), 64'(hbar));

      // Reset in the middle of CALC
      tick(); tick(); tick();
      check("mid_busy", 64'(w_busy), 64'd1);
      rst = 1'b0;
      tick();
      run = 1'b0;
      check("mrst_cells", 64'(w_cells), 64'd0);
      check("mrst_busy", 64'(w_busy), 64'd0);
      check("mrst_done", 64'(w_done), 64'd0);
      check("mrst_gen", 64'(w_gen), 64'd0);
      check("mrst_dgen", 64'(d_gen), 64'd0);
      check("mrst_pop", 64'(w_pop), 64'd0);
      check("mrst_stable", 64'(w_stable), 64'd0);
      check("mrst_extinct", 64'(w_extinct), 64'd1);
      rst = 1'b1;
      tick(); tick();
      check("post_rst_idle", 64'(w_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
